// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM encoding and one-hot helper for the 8-input round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int NUM_REQ       = 8;
    localparam int SEL_W         = 3;
    localparam int CNT_W         = 8;
    localparam int BURST_LEN_MIN = 1;
    localparam int BURST_LEN_MAX = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        idx_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority pick: first set request at or above the pointer, wrapping 7->0.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [SEL_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest requester above ptr is the last one kept.
    always_comb begin
        o_winner = {SEL_W{1'b0}};
        o_valid  = 1'b0;
        w_idx    = {SEL_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = i_ptr + SEL_W'(k);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end else begin
                o_winner = o_winner;
                o_valid  = o_valid;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving an 8x1 mux: bursts of up to BURST_LEN cycles per owner,
// a one-cycle GAP with burst_done after each grant, and fully registered outputs.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel0,
    output logic               sel1,
    output logic               sel2,
    output logic               enable,
    output logic               busy,
    output logic               burst_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    arb_state_e         r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_sel;
    logic               r_enable;
    logic               r_busy;
    logic               r_burst_done;

    logic [SEL_W-1:0]   w_winner;
    logic               w_valid;
    logic               w_exit;

    rr_pick8 u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // r_sel doubles as the owner index; release and burst limit collapse into one exit.
    assign w_exit = (~req[r_sel]) | (r_cnt == LAST_CNT);

    // Arbitration FSM with all mux-facing outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= {SEL_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_gnt        <= {NUM_REQ{1'b0}};
            r_sel        <= {SEL_W{1'b0}};
            r_enable     <= 1'b1;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_burst_done <= 1'b0;
                    if (w_valid) begin
                        r_state  <= ST_GRANT;
                        r_ptr    <= w_winner + 3'd1;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_gnt    <= idx_to_onehot(w_winner);
                        r_sel    <= w_winner;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_gnt    <= {NUM_REQ{1'b0}};
                        r_enable <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_exit) begin
                        r_state      <= ST_GAP;
                        r_gnt        <= {NUM_REQ{1'b0}};
                        r_enable     <= 1'b1;
                        r_burst_done <= 1'b1;
                    end else begin
                        r_state      <= ST_GRANT;
                        r_cnt        <= r_cnt + 8'd1;
                        r_burst_done <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_state      <= ST_IDLE;
                    r_gnt        <= {NUM_REQ{1'b0}};
                    r_enable     <= 1'b1;
                    r_busy       <= 1'b0;
                    r_burst_done <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_gnt        <= {NUM_REQ{1'b0}};
                    r_enable     <= 1'b1;
                    r_busy       <= 1'b0;
                    r_burst_done <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign sel0       = r_sel[0];
    assign sel1       = r_sel[1];
    assign sel2       = r_sel[2];
    assign enable     = r_enable;
    assign busy       = r_busy;
    assign burst_done = r_burst_done;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench: a vector table for reset, single-request and round-robin behaviour, then
// hand-written sequences for early release, simultaneous exit, mid-grant reset and BURST_LEN=1.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req_b;

    logic [7:0] gnt,   gnt_b;
    logic       sel0,  sel1,  sel2,  enable,   busy,   burst_done;
    logic       sel0_b, sel1_b, sel2_b, enable_b, busy_b, burst_done_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [13:0] exp;   // {gnt, sel[2:0], enable, busy, burst_done}
    } vec_t;

    vec_t vecs[$];

    mux8_rr_arbiter #(.BURST_LEN(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .sel0(sel0), .sel1(sel1), .sel2(sel2),
        .enable(enable), .busy(busy), .burst_done(burst_done)
    );

    mux8_rr_arbiter #(.BURST_LEN(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b),
        .sel0(sel0_b), .sel1(sel1_b), .sel2(sel2_b),
        .enable(enable_b), .busy(busy_b), .burst_done(burst_done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] pack(input logic [7:0] g, input logic [2:0] s,
                                         input logic e, input logic b, input logic d);
        pack = {g, s, e, b, d};
    endfunction

    function automatic void add(input int n, input logic r, input logic [7:0] rq,
                                input logic [7:0] g, input logic [2:0] s,
                                input logic e, input logic b, input logic d);
        vec_t v;
        v.rst = r;
        v.req = rq;
        v.exp = pack(g, s, e, b, d);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%h sel=%0d en=%b busy=%b done=%b, want gnt=%h sel=%0d en=%b busy=%b done=%b",
                     nm, act[13:6], act[5:3], act[2], act[1], act[0],
                     exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cyc(input logic r, input logic [7:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] s,
                       input logic e, input logic b, input logic d);
        check(nm, {gnt, sel2, sel1, sel0, enable, busy, burst_done}, pack(g, s, e, b, d));
    endtask

    task automatic chk_b(input string nm, input logic [7:0] g, input logic [2:0] s,
                         input logic e, input logic b, input logic d);
        check(nm, {gnt_b, sel2_b, sel1_b, sel0_b, enable_b, busy_b, burst_done_b},
              pack(g, s, e, b, d));
    endtask

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        req_b = 8'h00;

        // Reset for two cycles
        add(2, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        // Single request 0x04: 8 grant cycles, GAP, IDLE, regrant, then release
        add(8, 1'b0, 8'h04, 8'h04, 3'd2, 1'b0, 1'b1, 1'b0);
        add(1, 1'b0, 8'h04, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1);
        add(1, 1'b0, 8'h04, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 8'h04, 8'h04, 3'd2, 1'b0, 1'b1, 1'b0);
        add(1, 1'b0, 8'h00, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1);
        add(1, 1'b0, 8'h00, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0);
        // Reset pointer, then round-robin 0x81 held: 0,7,0,7
        add(1, 1'b1, 8'h81, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [2:0] o;
            o = (k % 2 == 0) ? 3'd0 : 3'd7;
            add(8, 1'b0, 8'h81, (k % 2 == 0) ? 8'h01 : 8'h80, o, 1'b0, 1'b1, 1'b0);
            add(1, 1'b0, 8'h81, 8'h00, o, 1'b1, 1'b1, 1'b1);
            add(1, 1'b0, (k == 3) ? 8'h00 : 8'h81, 8'h00, o, 1'b1, 1'b0, 1'b0);
        end

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d", i),
                  {gnt, sel2, sel1, sel0, enable, busy, burst_done}, vecs[i].exp);
        end

        // Early release: ptr is 0, req 0x10 dropped during the third granted cycle
        cyc(1'b0, 8'h10); chk("early_g1", 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h10); chk("early_g2", 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h10); chk("early_g3", 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00); chk("early_gap", 8'h00, 3'd4, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00); chk("early_idle", 8'h00, 3'd4, 1'b1, 1'b0, 1'b0);
        // ptr must now be 5: with bits 0 and 5 requesting, 5 wins
        cyc(1'b0, 8'h21); chk("ptr5_grant", 8'h20, 3'd5, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00); chk("ptr5_gap", 8'h00, 3'd5, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00); chk("ptr5_idle", 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);

        // Simultaneous exit: owner drops exactly when cnt reaches BURST_LEN-1
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h08);
            chk($sformatf("simul_g%0d", i), 8'h08, 3'd3, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 8'h00); chk("simul_gap", 8'h00, 3'd3, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00); chk("simul_idle1", 8'h00, 3'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00); chk("simul_idle2", 8'h00, 3'd3, 1'b1, 1'b0, 1'b0);

        // Reset mid-grant at cnt=4 with all requesting; ptr is 4 here
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'hFF);
            chk($sformatf("rstmid_g%0d", i), 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b1, 8'hFF); chk("rstmid_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'hFF); chk("rstmid_regrant", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00); chk("rstmid_gap", 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);

        // BURST_LEN=1 instance: each grant lasts exactly one cycle
        req_b = 8'h03;
        @(posedge clk); #1; chk_b("b1_g0", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1; chk_b("b1_gap0", 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1; chk_b("b1_idle0", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1; chk_b("b1_g1", 8'h02, 3'd1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1; chk_b("b1_gap1", 8'h00, 3'd1, 1'b1, 1'b1, 1'b1);
        req_b = 8'h00;
        @(posedge clk); #1; chk_b("b1_idle1", 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
